regfile_wb_arbiter: RTL and testbench

- Write-side controller for the three-ported register file. It is the sole driver of the file's we3/wa3/wd3 write port.
- It merges two writeback sources:
  - the in-order pipeline writeback, which has fixed priority and no backpressure;
  - a long-latency unit (mul/div/load-miss) with a valid/ready handshake, buffered in a small FIFO.
- It suppresses stale long-latency results (WAW) and reports per-register pending status to hazard logic.

---
 rtl/regfile_wb_arbiter.sv | 154 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the 3-port register file: merges the in-order pipeline
// writeback with a FIFO of long-latency results, kills stale (WAW) results, reports pending regs.
module regfile_wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pw_valid,
  input  logic [4:0]                 pw_rd,
  input  logic [31:0]                pw_data,
  input  logic                       ll_valid,
  output logic                       ll_ready,
  input  logic [4:0]                 ll_rd,
  input  logic [31:0]                ll_data,
  output logic                       we3,
  output logic [4:0]                 wa3,
  output logic [31:0]                wd3,
  input  logic [4:0]                 q_ra1,
  input  logic [4:0]                 q_ra2,
  output logic                       q_busy1,
  output logic                       q_busy2,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // FIFO storage: one {live, rd, data} entry per slot
  logic [DEPTH-1:0] live_q, live_d;
  logic [4:0]       rd_q   [DEPTH];
  logic [4:0]       rd_d   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic             we3_q, we3_d;
  logic [4:0]       wa3_q, wa3_d;
  logic [31:0]      wd3_q, wd3_d;

  logic             pw_fire;
  logic             push;
  logic             pop;
  logic [DEPTH-1:0] slot_valid;
  logic [PW-1:0]    slot_off;
  logic [31:0]      pend_vec;

  // Handshake: a long-latency result transfers on any cycle with ll_valid && ll_ready;
  // ll_ready depends only on the registered count, never on ll_valid or a same-cycle pop.
  assign ll_ready  = (count_q != CW'(DEPTH));
  assign pw_fire   = pw_valid && (pw_rd != 5'd0);
  assign push      = ll_valid && ll_ready && (ll_rd != 5'd0);
  assign pop       = !pw_fire && (count_q != '0);

  assign we3       = we3_q;
  assign wa3       = wa3_q;
  assign wd3       = wd3_q;
  assign occupancy = count_q;

  // A slot holds a queued entry when its distance from the read pointer is below the count
  always_comb begin
    slot_valid = '0;
    slot_off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_off      = PW'(i) - rd_ptr_q;
      slot_valid[i] = ({1'b0, slot_off} < count_q);
    end
  end

  // Per-register pending vector: the write in flight on the port plus every live queued entry
  always_comb begin
    pend_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i] && live_q[i]) begin
        pend_vec[rd_q[i]] = 1'b1;
      end
    end
    if (we3_q) begin
      pend_vec[wa3_q] = 1'b1;
    end
    pend_vec[0] = 1'b0;
  end

  assign q_busy1 = pend_vec[q_ra1];
  assign q_busy2 = pend_vec[q_ra2];

  always_comb begin
    we3_d    = 1'b0;
    wa3_d    = wa3_q;
    wd3_d    = wd3_q;
    live_d   = live_q;
    rd_d     = rd_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);

    if (pw_fire) begin
      we3_d = 1'b1;
      wa3_d = pw_rd;
      wd3_d = pw_data;
    end else if (pop) begin
      we3_d = live_q[rd_ptr_q];
      if (live_q[rd_ptr_q]) begin
        wa3_d = rd_q[rd_ptr_q];
        wd3_d = data_q[rd_ptr_q];
      end
    end

    // Older results to the same register are stale once the pipeline writes it
    for (int i = 0; i < DEPTH; i++) begin
      if (pw_fire && slot_valid[i] && (rd_q[i] == pw_rd)) begin
        live_d[i] = 1'b0;
      end
    end

    // Applied after the kill so a same-edge enqueue is treated as younger
    if (push) begin
      live_d[wr_ptr_q] = 1'b1;
      rd_d[wr_ptr_q]   = ll_rd;
      data_d[wr_ptr_q] = ll_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we3_q    <= 1'b0;
      wa3_q    <= '0;
      wd3_q    <= '0;
      live_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      we3_q    <= we3_d;
      wa3_q    <= wa3_d;
      wd3_q    <= wd3_d;
      live_q   <= live_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= rd_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        pw_valid;
  logic [4:0]  pw_rd;
  logic [31:0] pw_data;
  logic        ll_valid;
  logic        ll_ready;
  logic [4:0]  ll_rd;
  logic [31:0] ll_data;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic [4:0]  q_ra1;
  logic [4:0]  q_ra2;
  logic        q_busy1;
  logic        q_busy2;
  logic [$clog2(DEPTH):0] occupancy;

  regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .pw_valid(pw_valid), .pw_rd(pw_rd), .pw_data(pw_data),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_data(ll_data),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .q_ra1(q_ra1), .q_ra2(q_ra2), .q_busy1(q_busy1), .q_busy2(q_busy2),
    .occupancy(occupancy)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // reference model: pending results as a plain queue, write port as three variables
  typedef struct packed {
    logic        live;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        m_q[$];
  logic        m_we = 1'b0;
  logic [4:0]  m_wa = '0;
  logic [31:0] m_wd = '0;
  logic        started = 1'b0;
  logic [31:0] rf_dut [32];

  function automatic logic m_busy(input logic [4:0] q);
    if (q == 5'd0) return 1'b0;
    if (m_we && m_wa == q) return 1'b1;
    foreach (m_q[k]) if (m_q[k].live && m_q[k].rd == q) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_step();
    ent_t h;
    logic accept;
    if (reset) begin
      m_q.delete();
      m_we = 1'b0;
      m_wa = '0;
      m_wd = '0;
      return;
    end
    accept = ll_valid && (m_q.size() != DEPTH) && (ll_rd != 5'd0);
    if (pw_valid && pw_rd != 5'd0) begin
      foreach (m_q[k]) if (m_q[k].rd == pw_rd) m_q[k].live = 1'b0;
      m_we = 1'b1;
      m_wa = pw_rd;
      m_wd = pw_data;
    end else if (m_q.size() > 0) begin
      h = m_q.pop_front();
      m_we = h.live;
      if (h.live) begin
        m_wa = h.rd;
        m_wd = h.data;
      end
    end else begin
      m_we = 1'b0;
    end
    if (accept) m_q.push_back('{live: 1'b1, rd: ll_rd, data: ll_data});
  endtask

  // compare process: outputs against model mid-cycle, then advance model with the inputs
  // that the next rising edge will sample
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("cyc_we3", 32'(we3), 32'(m_we));
        chk("cyc_wa3", 32'(wa3), 32'(m_wa));
        chk("cyc_wd3", wd3, m_wd);
        chk("cyc_occupancy", 32'(occupancy), 32'(m_q.size()));
        chk("cyc_ll_ready", 32'(ll_ready), 32'(m_q.size() != DEPTH));
        chk("cyc_q_busy1", 32'(q_busy1), 32'(m_busy(q_ra1)));
        chk("cyc_q_busy2", 32'(q_busy2), 32'(m_busy(q_ra2)));
        if (we3) rf_dut[wa3] = wd3;
      end
      m_step();
      if (reset) started = 1'b1;
    end
  end

  // driver tasks
  task automatic drive(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    pw_valid = pv;
    pw_rd    = prd;
    pw_data  = pd;
    ll_valid = lv;
    ll_rd    = lrd;
    ll_data  = ld;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) rf_dut[i] = '0;
    reset = 1'b1;
    q_ra1 = 5'd5;
    q_ra2 = 5'd31;
    idle();
    repeat (2) step();
    reset = 1'b0;
    step();

    // reset then idle
    chk("rst_we3", 32'(we3), 32'd0);
    chk("rst_wa3", 32'(wa3), 32'd0);
    chk("rst_wd3", wd3, 32'd0);
    chk("rst_ll_ready", 32'(ll_ready), 32'd1);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_busy1", 32'(q_busy1), 32'd0);
    chk("rst_busy2", 32'(q_busy2), 32'd0);

    // priority: pipeline wins, long-latency result queued
    q_ra1 = 5'd6;
    drive(1'b1, 5'd5, 32'hAAAA0005, 1'b1, 5'd6, 32'h66);
    step();
    chk("pri_we3", 32'(we3), 32'd1);
    chk("pri_wa3", 32'(wa3), 32'd5);
    chk("pri_wd3", wd3, 32'hAAAA0005);
    chk("pri_occ", 32'(occupancy), 32'd1);
    chk("pri_busy6", 32'(q_busy1), 32'd1);
    idle();
    step();
    chk("pri_drain_wa3", 32'(wa3), 32'd6);
    chk("pri_drain_wd3", wd3, 32'h66);
    chk("pri_drain_occ", 32'(occupancy), 32'd0);
    step();
    chk("pri_done_we3", 32'(we3), 32'd0);
    chk("pri_done_busy6", 32'(q_busy1), 32'd0);

    // WAW kill
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h11);
    step();
    q_ra1 = 5'd7;
    drive(1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 32'd0);
    step();
    chk("waw_wa3", 32'(wa3), 32'd7);
    chk("waw_wd3", wd3, 32'h22);
    chk("waw_occ", 32'(occupancy), 32'd1);
    chk("waw_busy7", 32'(q_busy1), 32'd1);
    idle();
    step();
    chk("waw_kill_we3", 32'(we3), 32'd0);
    chk("waw_kill_occ", 32'(occupancy), 32'd0);
    chk("waw_kill_busy7", 32'(q_busy1), 32'd0);
    chk("waw_r7_final", rf_dut[7], 32'h22);

    // full / backpressure while pipeline starves the FIFO
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd1, 32'(i), 1'b1, 5'(10 + i), 32'h100 + 32'(i));
      step();
    end
    chk("full_occ", 32'(occupancy), 32'd4);
    chk("full_ready", 32'(ll_ready), 32'd0);
    drive(1'b1, 5'd1, 32'd4, 1'b1, 5'd14, 32'h1FF);
    step();
    chk("full_refused_occ", 32'(occupancy), 32'd4);
    idle();
    step();
    chk("drain0_wa3", 32'(wa3), 32'd10);
    chk("drain0_wd3", wd3, 32'h100);
    chk("drain0_occ", 32'(occupancy), 32'd3);
    chk("drain0_ready", 32'(ll_ready), 32'd1);
    for (int k = 1; k < 4; k++) begin
      step();
      chk("drain_wa3", 32'(wa3), 32'(10 + k));
      chk("drain_wd3", wd3, 32'h100 + 32'(k));
    end

    // zero-register handling
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
    step();
    chk("zero_ll_occ", 32'(occupancy), 32'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h33);
    step();
    chk("zero_push_occ", 32'(occupancy), 32'd1);
    q_ra1 = 5'd0;
    q_ra2 = 5'd3;
    drive(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0);
    step();
    chk("zero_pw_we3", 32'(we3), 32'd1);
    chk("zero_pw_wa3", 32'(wa3), 32'd3);
    chk("zero_pw_wd3", wd3, 32'h33);
    chk("zero_pw_occ", 32'(occupancy), 32'd0);
    chk("zero_q_busy1", 32'(q_busy1), 32'd0);
    chk("zero_q_busy2", 32'(q_busy2), 32'd1);

    // pointer wrap with simultaneous push and pop
    idle();
    step();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(8 + (i % 2)), 32'h800 + 32'(i));
      step();
      if (i > 0) begin
        chk("wrap_wa3", 32'(wa3), 32'(8 + ((i - 1) % 2)));
        chk("wrap_wd3", wd3, 32'h800 + 32'(i - 1));
        chk("wrap_occ", 32'(occupancy), 32'd1);
      end
    end
    idle();
    step();
    chk("wrap_last_wa3", 32'(wa3), 32'd9);
    chk("wrap_last_wd3", wd3, 32'h809);
    chk("wrap_last_occ", 32'(occupancy), 32'd0);

    // mid-operation reset discards queued results
    q_ra1 = 5'd20;
    q_ra2 = 5'd22;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd2, 32'h200 + 32'(i), 1'b1, 5'(20 + i), 32'h300 + 32'(i));
      step();
    end
    chk("mrst_pre_occ", 32'(occupancy), 32'd3);
    chk("mrst_pre_busy", 32'(q_busy1), 32'd1);
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mrst_occ", 32'(occupancy), 32'd0);
    chk("mrst_we3", 32'(we3), 32'd0);
    chk("mrst_wa3", 32'(wa3), 32'd0);
    chk("mrst_wd3", wd3, 32'd0);
    chk("mrst_busy1", 32'(q_busy1), 32'd0);
    chk("mrst_busy2", 32'(q_busy2), 32'd0);
    chk("mrst_ready", 32'(ll_ready), 32'd1);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
